// File: rtl/ldm_stm_sequencer_pkg.sv
// Shared types and constants for the LDM/STM multi-register transfer sequencer.
package ldm_stm_sequencer_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StAddr,
    StXfer,
    StWb,
    StDone,
    StErr
  } state_e;

  // Addressing mode 4, encoded as {p_bit, u_bit}
  typedef enum logic [1:0] {
    ModeDa = 2'b00,
    ModeIa = 2'b01,
    ModeDb = 2'b10,
    ModeIb = 2'b11
  } mode_e;

  localparam int unsigned DefaultWordBytes = 4;

endpackage

// File: rtl/ldm_stm_sequencer_lowest_set_bit_enc.sv
// Priority encoder: index of the lowest set bit of a vector, plus an any-bit-set flag.
module ldm_stm_sequencer_lowest_set_bit_enc #(
  parameter int unsigned Width = 16,
  localparam int unsigned IdxW = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] vec_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             any_o
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = int'(Width) - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = IdxW'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: walks a register list, driving MAR/MDR/RF strobes with a MOC
// handshake, optional base writeback, and a MOC timeout that aborts the transfer.
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned WORD_BYTES  = DefaultWordBytes,
  parameter int unsigned MOC_TIMEOUT = 15,
  localparam int unsigned RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic                p_bit_i,
  input  logic                u_bit_i,
  input  logic                w_bit_i,
  input  logic                l_bit_i,
  input  logic [RW-1:0]       rn_idx_i,
  input  logic [NUM_REGS-1:0] reg_list_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  input  logic                moc_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                error_o,
  output logic                mar_ld_o,
  output logic [ADDR_W-1:0]   mar_addr_o,
  output logic                mdr_ld_o,
  output logic                mov_o,
  output logic                r_w_o,
  output logic [RW-1:0]       rf_sel_o,
  output logic                rf_ld_o,
  output logic                wb_ld_o,
  output logic [ADDR_W-1:0]   wb_value_o
);

  localparam int unsigned CW = RW + 1;
  localparam int unsigned TW = $clog2(MOC_TIMEOUT + 1);

  function automatic logic [CW-1:0] popcount(input logic [NUM_REGS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < int'(NUM_REGS); i++) c = c + CW'(v[i]);
    return c;
  endfunction

  state_e              state_q;
  mode_e               mode_q;
  logic                l_q, wb_en_q;
  logic [NUM_REGS-1:0] list_q;
  logic [ADDR_W-1:0]   base_q, addr_q;
  logic [TW-1:0]       cnt_q;

  logic                busy_q, done_q, error_q, mar_ld_q, mdr_ld_q, mov_q, r_w_q, wb_ld_q;
  logic [ADDR_W-1:0]   mar_addr_q, wb_value_q;
  logic [RW-1:0]       rf_sel_q;

  logic [ADDR_W-1:0]   stride, span, start_addr, wb_calc, next_addr;
  logic [NUM_REGS-1:0] list_rest, enc_in;
  logic [RW-1:0]       enc_idx;
  logic                enc_any;

  // Start address and writeback value by mode; remaining list after the current transfer
  always_comb begin
    stride     = ADDR_W'(WORD_BYTES);
    span       = ADDR_W'(popcount(list_q)) * stride;
    start_addr = base_q;
    case (mode_q)
      ModeIa:  start_addr = base_q;
      ModeIb:  start_addr = base_q + stride;
      ModeDa:  start_addr = base_q - span + stride;
      ModeDb:  start_addr = base_q - span;
      default: start_addr = base_q;
    endcase
    wb_calc   = mode_q[0] ? base_q + span : base_q - span;
    next_addr = addr_q + stride;
    // rf_sel is always the lowest set bit, so x & (x-1) clears exactly that one
    list_rest = list_q & (list_q - NUM_REGS'(1));
    enc_in    = (state_q == StXfer) ? list_rest : list_q;
  end

  ldm_stm_sequencer_lowest_set_bit_enc #(
    .Width (NUM_REGS)
  ) u_lsb_enc (
    .vec_i (enc_in),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // Sequencer FSM with registered strobes
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      mode_q     <= ModeDa;
      l_q        <= 1'b0;
      wb_en_q    <= 1'b0;
      list_q     <= '0;
      base_q     <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      mar_ld_q   <= 1'b0;
      mar_addr_q <= '0;
      mdr_ld_q   <= 1'b0;
      mov_q      <= 1'b0;
      r_w_q      <= 1'b0;
      rf_sel_q   <= '0;
      wb_ld_q    <= 1'b0;
      wb_value_q <= '0;
    end else begin
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      mar_ld_q <= 1'b0;
      mdr_ld_q <= 1'b0;
      wb_ld_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            mode_q  <= mode_e'({p_bit_i, u_bit_i});
            l_q     <= l_bit_i;
            // A load that includes the base register keeps the loaded value
            wb_en_q <= w_bit_i & ~(l_bit_i & reg_list_i[rn_idx_i]);
            list_q  <= reg_list_i;
            base_q  <= base_addr_i;
            busy_q  <= 1'b1;
            state_q <= StSetup;
          end
        end
        StSetup: begin
          wb_value_q <= wb_calc;
          addr_q     <= start_addr;
          if (!enc_any) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            mar_ld_q   <= 1'b1;
            mar_addr_q <= start_addr;
            rf_sel_q   <= enc_idx;
            mdr_ld_q   <= ~l_q;
            state_q    <= StAddr;
          end
        end
        StAddr: begin
          mov_q   <= 1'b1;
          r_w_q   <= l_q;
          cnt_q   <= '0;
          state_q <= StXfer;
        end
        StXfer: begin
          if (moc_i) begin
            list_q <= list_rest;
            addr_q <= next_addr;
            cnt_q  <= '0;
            mov_q  <= 1'b0;
            r_w_q  <= 1'b0;
            if (enc_any) begin
              mar_ld_q   <= 1'b1;
              mar_addr_q <= next_addr;
              rf_sel_q   <= enc_idx;
              mdr_ld_q   <= ~l_q;
              state_q    <= StAddr;
            end else if (wb_en_q) begin
              wb_ld_q <= 1'b1;
              state_q <= StWb;
            end else begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end else if (cnt_q == TW'(MOC_TIMEOUT - 1)) begin
            mov_q   <= 1'b0;
            r_w_q   <= 1'b0;
            error_q <= 1'b1;
            state_q <= StErr;
          end else begin
            cnt_q <= cnt_q + TW'(1);
          end
        end
        StWb: begin
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StDone, StErr: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign mar_ld_o   = mar_ld_q;
  assign mar_addr_o = mar_addr_q;
  assign mdr_ld_o   = mdr_ld_q;
  assign mov_o      = mov_q;
  assign r_w_o      = r_w_q;
  assign rf_sel_o   = rf_sel_q;
  assign wb_ld_o    = wb_ld_q;
  assign wb_value_o = wb_value_q;
  // Load data is written back in the same cycle the memory completes
  assign rf_ld_o    = (state_q == StXfer) & l_q & moc_i;

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: stimulus queues expected events, a monitor
// pops and compares them as the DUT presents strobes.
`timescale 1ns/1ps
module tb_ldm_stm_sequencer;

  localparam int unsigned NR = 16;
  localparam int unsigned AW = 32;
  localparam int unsigned RW = 4;

  logic          clk_i = 1'b0, rst_ni = 1'b1;
  logic          start_i = 1'b0, p_bit_i = 1'b0, u_bit_i = 1'b0, w_bit_i = 1'b0, l_bit_i = 1'b0;
  logic [RW-1:0] rn_idx_i = '0;
  logic [NR-1:0] reg_list_i = '0;
  logic [AW-1:0] base_addr_i = '0;
  logic          moc_i = 1'b0;
  logic          busy_o, done_o, error_o, mar_ld_o, mdr_ld_o, mov_o, r_w_o, rf_ld_o, wb_ld_o;
  logic [AW-1:0] mar_addr_o, wb_value_o;
  logic [RW-1:0] rf_sel_o;

  always #5 clk_i = ~clk_i;

  ldm_stm_sequencer dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .start_i     (start_i),
    .p_bit_i     (p_bit_i),
    .u_bit_i     (u_bit_i),
    .w_bit_i     (w_bit_i),
    .l_bit_i     (l_bit_i),
    .rn_idx_i    (rn_idx_i),
    .reg_list_i  (reg_list_i),
    .base_addr_i (base_addr_i),
    .moc_i       (moc_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o),
    .mar_ld_o    (mar_ld_o),
    .mar_addr_o  (mar_addr_o),
    .mdr_ld_o    (mdr_ld_o),
    .mov_o       (mov_o),
    .r_w_o       (r_w_o),
    .rf_sel_o    (rf_sel_o),
    .rf_ld_o     (rf_ld_o),
    .wb_ld_o     (wb_ld_o),
    .wb_value_o  (wb_value_o)
  );

  typedef struct packed {logic [63:0] name; logic [63:0] act; logic [63:0] exp;} req_t;

  logic [AW+RW:0] exp_mar[$];  // {addr, rf_sel, mdr_ld}
  logic [RW-1:0]  exp_rf[$];
  logic [AW-1:0]  exp_wb[$];
  logic           exp_end[$];  // 0 = done, 1 = error
  req_t           req_q[$];

  int n_tests = 0, n_fail = 0;
  int hs_count = 0, end_count = 0, end_cyc = 0, cyc = 0;
  int hs_base = 0, dly = 0, allow = 0, mov_run = 0, start_cyc = 0, ends_before = 0;
  logic exp_rw = 1'b0;
  req_t mon_r;

  task automatic chk(input logic [63:0] name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %0s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_chk(input logic [63:0] name, input logic [63:0] act,
                          input logic [63:0] exp);
    req_q.push_back({name, act, exp});
  endtask

  always @(posedge clk_i) cyc++;

  // Memory model: answer mov after dly extra cycles, for at most allow transfers
  always @(posedge clk_i) begin
    #1;
    if (mov_o) mov_run++;
    else mov_run = 0;
    moc_i = mov_o && (mov_run > dly) && ((hs_count - hs_base) < allow);
  end

  // Monitor: drain stimulus-side checks, then score DUT strobes
  always @(negedge clk_i) begin
    while (req_q.size() > 0) begin
      mon_r = req_q.pop_front();
      chk(mon_r.name, mon_r.act, mon_r.exp);
    end
    if (rst_ni) begin
      if (mov_o && moc_i) begin
        hs_count++;
        chk("r_w", 64'(r_w_o), 64'(exp_rw));
      end
      if (mar_ld_o) begin
        if (exp_mar.size() == 0) chk("mar_xtra", 1, 0);
        else chk("mar", 64'({mar_addr_o, rf_sel_o, mdr_ld_o}), 64'(exp_mar.pop_front()));
      end
      if (rf_ld_o) begin
        if (exp_rf.size() == 0) chk("rf_xtra", 1, 0);
        else chk("rf_ld", 64'(rf_sel_o), 64'(exp_rf.pop_front()));
      end
      if (wb_ld_o) begin
        if (exp_wb.size() == 0) chk("wb_xtra", 1, 0);
        else chk("wb", 64'(wb_value_o), 64'(exp_wb.pop_front()));
      end
      if (done_o || error_o) begin
        end_count++;
        end_cyc = cyc;
        chk("end_busy", 64'(busy_o), 1);
        if (exp_end.size() == 0) chk("end_xtra", 1, 0);
        else chk("end", 64'({error_o, done_o}), exp_end.pop_front() ? 64'd2 : 64'd1);
        if (error_o) chk("err_mov", 64'(mov_o), 0);
      end
    end
  end

  task automatic issue(input logic p, input logic u, input logic w, input logic l,
                       input logic [RW-1:0] rn, input logic [NR-1:0] list,
                       input logic [AW-1:0] base, input int d, input int a);
    @(posedge clk_i);
    #1;
    dly = d;
    allow = a;
    hs_base = hs_count;
    exp_rw = l;
    ends_before = end_count;
    p_bit_i = p; u_bit_i = u; w_bit_i = w; l_bit_i = l;
    rn_idx_i = rn; reg_list_i = list; base_addr_i = base;
    start_i = 1'b1;
    start_cyc = cyc;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    // Inputs must be ignored once busy
    p_bit_i = ~p; u_bit_i = ~u; w_bit_i = ~w; l_bit_i = ~l;
    rn_idx_i = ~rn; reg_list_i = '1; base_addr_i = ~base;
    push_chk("busy", 64'(busy_o), 1);
  endtask

  task automatic wait_end();
    int b = 0;
    while (end_count == ends_before && b < 500) begin
      @(posedge clk_i);
      b++;
    end
    if (end_count == ends_before) push_chk("timeout", 1, 0);
    @(posedge clk_i);
    #1;
    push_chk("idle", 64'(busy_o), 0);
    push_chk("leftover", 64'(exp_mar.size() + exp_rf.size() + exp_wb.size() + exp_end.size()), 0);
  endtask

  initial begin
    #2 rst_ni = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    push_chk("rst_ctl", 64'({busy_o, done_o, error_o, mar_ld_o, mdr_ld_o, mov_o, r_w_o, rf_ld_o,
                             wb_ld_o, rf_sel_o}), 0);
    push_chk("rst_mar", 64'(mar_addr_o), 0);
    push_chk("rst_wbv", 64'(wb_value_o), 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // STMIA, no writeback
    exp_mar.push_back({32'h100, 4'd0, 1'b1});
    exp_mar.push_back({32'h104, 4'd1, 1'b1});
    exp_mar.push_back({32'h108, 4'd2, 1'b1});
    exp_mar.push_back({32'h10C, 4'd3, 1'b1});
    exp_end.push_back(1'b0);
    issue(1'b0, 1'b1, 1'b0, 1'b0, 4'd9, 16'h000F, 32'h100, 0, 99);
    wait_end();

    // LDMDB with writeback
    exp_mar.push_back({32'h1F8, 4'd0, 1'b0});
    exp_mar.push_back({32'h1FC, 4'd15, 1'b0});
    exp_rf.push_back(4'd0);
    exp_rf.push_back(4'd15);
    exp_wb.push_back(32'h1F8);
    exp_end.push_back(1'b0);
    issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 16'h8001, 32'h200, 0, 99);
    wait_end();

    // LDMIB with Rn in the list: writeback suppressed
    exp_mar.push_back({32'h304, 4'd1, 1'b0});
    exp_mar.push_back({32'h308, 4'd2, 1'b0});
    exp_rf.push_back(4'd1);
    exp_rf.push_back(4'd2);
    exp_end.push_back(1'b0);
    issue(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 16'h0006, 32'h300, 0, 99);
    wait_end();

    // Empty list: done two cycles after start, nothing else
    exp_end.push_back(1'b0);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 4'd1, 16'h0000, 32'h700, 0, 99);
    wait_end();
    push_chk("latency", 64'(end_cyc - start_cyc), 2);

    // STMDA with writeback, slow memory
    exp_mar.push_back({32'h3FC, 4'd4, 1'b1});
    exp_mar.push_back({32'h400, 4'd5, 1'b1});
    exp_wb.push_back(32'h3F8);
    exp_end.push_back(1'b0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 16'h0030, 32'h400, 2, 99);
    wait_end();

    // LDMIA: memory stops answering after one transfer -> timeout
    exp_mar.push_back({32'h500, 4'd0, 1'b0});
    exp_mar.push_back({32'h504, 4'd1, 1'b0});
    exp_rf.push_back(4'd0);
    exp_end.push_back(1'b1);
    issue(1'b0, 1'b1, 1'b1, 1'b1, 4'd8, 16'h0007, 32'h500, 0, 1);
    wait_end();

    // Async reset in the middle of a transfer
    exp_mar.push_back({32'h600, 4'd0, 1'b1});
    issue(1'b0, 1'b1, 1'b1, 1'b0, 4'd8, 16'h0003, 32'h600, 0, 0);
    begin
      int b = 0;
      while (!mov_o && b < 20) begin
        @(posedge clk_i);
        #1;
        b++;
      end
      push_chk("mov_wait", 64'(mov_o), 1);
    end
    #2 rst_ni = 1'b0;
    #1;
    push_chk("xrst_ctl", 64'({busy_o, done_o, error_o, mar_ld_o, mdr_ld_o, mov_o, r_w_o, rf_ld_o,
                              wb_ld_o, rf_sel_o}), 0);
    push_chk("xrst_mar", 64'(mar_addr_o), 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    push_chk("leftover", 64'(exp_mar.size() + exp_rf.size() + exp_wb.size() + exp_end.size()), 0);

    // STMIA across the top of the address space
    exp_mar.push_back({32'hFFFF_FFFC, 4'd0, 1'b1});
    exp_mar.push_back({32'h0000_0000, 4'd1, 1'b1});
    exp_wb.push_back(32'h0000_0004);
    exp_end.push_back(1'b0);
    issue(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, 16'h0003, 32'hFFFF_FFFC, 0, 99);
    wait_end();

    repeat (3) @(negedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

endmodule
